// File: rtl/clk_switch_ctrl.sv
// clk_switch_ctrl: drives the select of the glitch-free clock mux.
// A request is only honoured once the target clock shows a heartbeat edge.
// After that, sel is held for a settle window that covers the mux's two-edge
// handover, and only then is done reported. A dead target aborts with err.
module clk_switch_ctrl #(
  parameter int SETTLE_CYCLES = 8,
  parameter int TIMEOUT       = 64,
  parameter int CNT_W         = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic req_valid,
  input  logic req_sel,
  output logic req_ready,
  input  logic hb0,
  input  logic hb1,
  output logic sel,
  output logic busy,
  output logic done,
  output logic err
);

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    CHECK  = 2'b01,
    SWITCH = 2'b10
  } state_t;

  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST  = CNT_W'(SETTLE_CYCLES - 1);

  state_t           state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic             target, target_next;
  logic             sel_next, done_next, err_next;

  // Bit 0 and bit 1 are the two synchronizer stages. Bit 2 delays the synced
  // value by one more cycle so that a heartbeat toggle becomes a one-cycle pulse.
  logic [2:0] hb0_sync, hb1_sync;
  logic       hb0_edge, hb1_edge, target_edge;

  // Bring both heartbeats into the clk domain and delay them for edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      hb0_sync <= '0;
      hb1_sync <= '0;
    end else begin
      hb0_sync <= {hb0_sync[1:0], hb0};
      hb1_sync <= {hb1_sync[1:0], hb1};
    end
  end

  assign hb0_edge    = hb0_sync[1] ^ hb0_sync[2];
  assign hb1_edge    = hb1_sync[1] ^ hb1_sync[2];
  assign target_edge = target ? hb1_edge : hb0_edge;

  assign req_ready = (state == IDLE);
  assign busy      = (state == CHECK) || (state == SWITCH);

  // State register plus the registered outputs, which makes done/err clean one-cycle pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      target <= 1'b0;
      sel    <= 1'b0;
      done   <= 1'b0;
      err    <= 1'b0;
    end else begin
      state  <= state_next;
      cnt    <= cnt_next;
      target <= target_next;
      sel    <= sel_next;
      done   <= done_next;
      err    <= err_next;
    end
  end

  // Next-state logic: accept, then check liveness, then settle. An edge beats a timeout in the same cycle.
  always_comb begin
    state_next  = state;
    cnt_next    = cnt;
    target_next = target;
    sel_next    = sel;
    done_next   = 1'b0;
    err_next    = 1'b0;
    case (state)
      IDLE: begin
        if (req_valid && req_ready) begin
          target_next = req_sel;
          if (req_sel == sel) begin
            done_next = 1'b1;
          end else begin
            state_next = CHECK;
            cnt_next   = '0;
          end
        end
      end
      CHECK: begin
        if (target_edge) begin
          state_next = SWITCH;
          sel_next   = target;
          cnt_next   = '0;
        end else if (cnt == TIMEOUT_LAST) begin
          state_next = IDLE;
          err_next   = 1'b1;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      SWITCH: begin
        if (cnt == SETTLE_LAST) begin
          state_next = IDLE;
          done_next  = 1'b1;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_clk_switch_ctrl.sv
// Testbench for clk_switch_ctrl. It keeps a scoreboard of expected request
// outcomes. The heartbeats are generated in step with clk so that the arrival
// of a target edge can be placed on an exact CHECK cycle.
module tb_clk_switch_ctrl;

  logic clk = 1'b0;
  logic rst, req_valid, req_sel, hb0, hb1;
  logic req_ready, sel, busy, done, err;

  always #5 clk = ~clk;

  clk_switch_ctrl #(.SETTLE_CYCLES(8), .TIMEOUT(64), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_sel(req_sel),
    .req_ready(req_ready), .hb0(hb0), .hb1(hb1), .sel(sel),
    .busy(busy), .done(done), .err(err)
  );

  typedef struct {
    bit isErr;
    bit selAfter;
    int expBusy;
    int expLat;
  } exp_t;

  exp_t sb[$];

  int testsRun = 0, testsFailed = 0;
  int cycleNo = 0, busyCycles = 0, doneCount = 0;
  int selRiseCycle = 0, acceptCycle = 0, lastEventCycle = 0;
  int hbPer0 = 0, hbPer1 = 0, hbCnt0 = 0, hbCnt1 = 0;
  logic prevSel = 1'b0;

  task automatic checkOutput(input string tag, input int observed, input int expected);
    testsRun++;
    if (observed != expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  // Advance one clock, sample outputs just after the edge, then update the heartbeats.
  task automatic tick();
    @(posedge clk);
    #1;
    cycleNo++;
    if (busy === 1'b1) busyCycles++;
    if (done === 1'b1) doneCount++;
    if (sel === 1'b1 && prevSel !== 1'b1) selRiseCycle = cycleNo;
    prevSel = sel;
    if (hbPer0 > 0) begin
      hbCnt0++;
      if (hbCnt0 >= hbPer0) begin hb0 = ~hb0; hbCnt0 = 0; end
    end
    if (hbPer1 > 0) begin
      hbCnt1++;
      if (hbCnt1 >= hbPer1) begin hb1 = ~hb1; hbCnt1 = 0; end
    end
  endtask

  // Present one request for a single cycle and record its expected outcome.
  task automatic applyStimulus(input bit s, input bit expErr, input bit expSel,
                               input int expBusy, input int expLat);
    exp_t e;
    e.isErr = expErr;
    e.selAfter = expSel;
    e.expBusy = expBusy;
    e.expLat = expLat;
    sb.push_back(e);
    req_valid = 1'b1;
    req_sel = s;
    busyCycles = 0;
    acceptCycle = cycleNo + 1;
    tick();
    req_valid = 1'b0;
    req_sel = ~s;
  endtask

  // Wait (bounded) for a done or err pulse, then compare it against the scoreboard entry.
  task automatic waitResult(input string tag, input int maxTicks);
    int waited = 0;
    exp_t e;
    while (!(done === 1'b1 || err === 1'b1) && waited < maxTicks) begin
      tick();
      waited++;
    end
    lastEventCycle = cycleNo;
    if (!(done === 1'b1 || err === 1'b1)) begin
      checkOutput({tag, "_timeout"}, 0, 1);
      if (sb.size() > 0) void'(sb.pop_front());
    end else if (sb.size() == 0) begin
      checkOutput({tag, "_unexpected"}, 1, 0);
    end else begin
      e = sb.pop_front();
      checkOutput({tag, "_err"}, int'(err), int'(e.isErr));
      checkOutput({tag, "_done"}, int'(done), int'(!e.isErr));
      checkOutput({tag, "_sel"}, int'(sel), int'(e.selAfter));
      checkOutput({tag, "_ready"}, int'(req_ready), 1);
      checkOutput({tag, "_busyLow"}, int'(busy), 0);
      if (e.expBusy >= 0) checkOutput({tag, "_busyCycles"}, busyCycles, e.expBusy);
      if (e.expLat >= 0) checkOutput({tag, "_latency"}, waited, e.expLat);
      tick();
      checkOutput({tag, "_pulseEnd"}, int'(done | err), 0);
    end
  endtask

  initial begin
    int n;
    int d0;
    rst = 1'b1; req_valid = 1'b0; req_sel = 1'b0; hb0 = 1'b0; hb1 = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    checkOutput("rst_sel", int'(sel), 0);
    checkOutput("rst_busy", int'(busy), 0);
    checkOutput("rst_done", int'(done), 0);
    checkOutput("rst_err", int'(err), 0);
    checkOutput("rst_ready", int'(req_ready), 1);

    // A request for the already-selected source completes on the next cycle.
    applyStimulus(1'b0, 1'b0, 1'b0, 0, 0);
    waitResult("noop", 4);

    // Nominal switch to a live clk1.
    hbPer1 = 3;
    repeat (10) tick();
    applyStimulus(1'b1, 1'b0, 1'b1, -1, -1);
    checkOutput("nom_busyNext", int'(busy), 1);
    waitResult("nominal", 40);
    checkOutput("nom_selLatency", int'((selRiseCycle - acceptCycle) <= 5), 1);
    checkOutput("nom_settle", lastEventCycle - selRiseCycle, 8);

    // Dead target: hb0 has never toggled.
    applyStimulus(1'b0, 1'b1, 1'b1, 64, 64);
    waitResult("dead", 80);

    // The edge reaches the last CHECK cycle (counter 63), so the switch is taken.
    applyStimulus(1'b0, 1'b0, 1'b0, 72, -1);
    repeat (61) tick();
    hb0 = ~hb0;
    waitResult("edgeLast", 100);

    // The edge arrives one cycle too late, so the request times out.
    hbPer1 = 0;
    repeat (6) tick();
    applyStimulus(1'b1, 1'b1, 1'b0, 64, -1);
    repeat (62) tick();
    hb1 = ~hb1;
    waitResult("edgeLate", 100);

    // A request presented during SWITCH must be ignored.
    hbPer1 = 3;
    repeat (6) tick();
    d0 = doneCount;
    applyStimulus(1'b1, 1'b0, 1'b1, -1, -1);
    n = 0;
    while (sel !== 1'b1 && n < 20) begin tick(); n++; end
    checkOutput("ign_inSwitch", int'(sel === 1'b1), 1);
    repeat (2) tick();
    req_valid = 1'b1;
    req_sel = 1'b0;
    checkOutput("ign_ready", int'(req_ready), 0);
    tick();
    req_valid = 1'b0;
    waitResult("ignore", 20);
    repeat (12) tick();
    checkOutput("ign_oneDone", doneCount - d0, 1);
    checkOutput("ign_selEnd", int'(sel), 1);

    // Return to clk0 so the next switch is 0 -> 1.
    hbPer0 = 2;
    repeat (6) tick();
    applyStimulus(1'b0, 1'b0, 1'b0, -1, -1);
    waitResult("back", 40);

    // Reset in the middle of SWITCH, then make a fresh request.
    applyStimulus(1'b1, 1'b0, 1'b1, -1, -1);
    n = 0;
    while (sel !== 1'b1 && n < 20) begin tick(); n++; end
    checkOutput("mid_reachedSwitch", int'(sel === 1'b1), 1);
    repeat (2) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    sb.delete();
    checkOutput("mid_sel", int'(sel), 0);
    checkOutput("mid_busy", int'(busy), 0);
    checkOutput("mid_done", int'(done), 0);
    checkOutput("mid_err", int'(err), 0);
    checkOutput("mid_ready", int'(req_ready), 1);
    applyStimulus(1'b1, 1'b0, 1'b1, -1, -1);
    waitResult("afterRst", 40);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/clk_switch_ctrl.md
Name: clk_switch_ctrl

Overview:
- Single-clock controller that produces the `sel` input of the glitch-free clock mux.
- Accepts switch requests over a valid/ready handshake and checks that the target source clock is alive, using a toggling heartbeat from that clock's domain.
- Drives `sel`, then waits a settle window covering the mux's two-edge handover before reporting done.
- Aborts with an error pulse if the target clock is dead.

Parameters:
- SETTLE_CYCLES, 8: cycles `sel` is held in SWITCH before done. Must be ≥1 and <2^CNT_W.
- TIMEOUT, 64: CHECK cycles allowed for a target heartbeat edge before abort. Must be ≥1 and ≤2^CNT_W.
- CNT_W, 8: width of the shared cycle counter.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous active-high reset.
- req_valid  in  1  switch request valid.
- req_sel  in  1  requested source (0 = clk0, 1 = clk1).
- req_ready  out  1  high only in IDLE.
- hb0  in  1  heartbeat, toggled every clk0 cycle; asynchronous to clk.
- hb1  in  1  heartbeat, toggled every clk1 cycle; asynchronous to clk.
- sel  out  1  registered mux select.
- busy  out  1  high in CHECK and SWITCH.
- done  out  1  one-cycle pulse: request completed (switched or no-op).
- err  out  1  one-cycle pulse: request aborted, target heartbeat timeout.

Behaviour:
- Reset: synchronous active-high. Takes effect on the clk edge where rst=1, at any point including mid-operation. Values after reset:
  - state = IDLE, sel = 0, busy = 0, done = 0, err = 0, req_ready = 1.
  - counter = 0, stored target = 0.
  - All heartbeat sync/edge flops = 0.
- Heartbeat path, per hbN:
  - 2-flop synchronizer, then a third flop; hbN_edge = s2 XOR s3.
  - Latency from hb toggle to hbN_edge is 2–3 clk cycles.
  - Only the target's edge is used. The other heartbeat is ignored.
- IDLE:
  - req_ready = 1.
  - Handshake fires on a clk edge with req_valid & req_ready; req_sel is latched as target.
  - If req_sel == sel: no-op. Next cycle stays IDLE with done = 1, sel unchanged, busy stays 0.
  - Otherwise: next state CHECK, counter = 0, busy = 1.
- CHECK:
  - If the target hb_edge is 1 this cycle: next state SWITCH, sel <= target, counter <= 0.
  - Else if counter == TIMEOUT-1: next state IDLE with err = 1 for that cycle; sel unchanged, busy = 0.
  - Else counter increments.
  - If hb_edge and timeout coincide, hb_edge wins and the block switches.
  - CHECK lasts at most TIMEOUT cycles.
- SWITCH:
  - sel holds the new value.
  - Counter increments each cycle. When counter == SETTLE_CYCLES-1, next state IDLE with done = 1 for that cycle, busy = 0.
  - SWITCH lasts exactly SETTLE_CYCLES cycles.
- Handshake rules:
  - req_ready = (state == IDLE), so it is 1 in the cycle that done or err pulses, and a new request can be accepted that cycle.
  - req_valid while busy is ignored; no queuing.
  - req_sel is sampled only at the handshake; later changes have no effect.
- Outputs:
  - done and err are never high together and are never high outside the first IDLE cycle after completion.
  - sel changes only on the CHECK→SWITCH transition or at reset.
- Counter: unsigned, CNT_W bits, never wraps within legal parameters.
- Unused state encodings recover to IDLE with busy = 0 and sel unchanged.

Test Plan:
- Reset then no-op: rst held 3 cycles, then req_valid=1, req_sel=0 for 1 cycle → sel=0, done=1 exactly 1 cycle later, busy never 1, err=0.
- Nominal switch: hb1 toggling every 3 clk; request req_sel=1 → busy=1 next cycle, sel=1 within 5 cycles of accept, done=1 exactly 8 cycles after the sel rise, req_ready=1 on the done cycle.
- Dead target: hb0 static, sel=1, request req_sel=0 → busy for exactly 64 cycles (TIMEOUT), then err=1 for 1 cycle, sel stays 1, done stays 0.
- Timeout boundary: force the target hb_edge to first occur in CHECK cycle 64 (counter=63) → SWITCH taken, sel flips, err=0; a second run with the edge one cycle later → err=1.
- Busy-ignore: during SWITCH, pulse req_valid with req_sel=0 → no effect, req_ready=0, exactly one done; sel ends at 1.
- Reset mid-operation: assert rst in SWITCH with sel=1 → next cycle sel=0, busy=0, done=0, err=0, req_ready=1; a fresh request then completes normally.
